// File: rtl/peripheral_dbg_pu_or1k_jsp_arbiter.sv
// ---------------------------------------------------------------------------
// peripheral_dbg_pu_or1k_jsp_arbiter
//
// Shares one JSP WishBone slave (16550-style JTAG serial port BIU) among
// NUM_MASTERS CPU data ports. One master owns the slave for a whole WB cycle
// (cyc held high). Arbitration is round-robin between cycles. A bus-hang
// timer terminates a stalled access with an error. The JSP interrupt is
// routed to the core that last wrote the TX FIFO byte.
//
// Ports
//   wb_clk_i, wb_rst_i          clock; asynchronous active-high reset
//   m_adr_i/m_dat_i/m_sel_i/
//   m_we_i/m_cyc_i/m_stb_i/
//   m_cti_i/m_bte_i             packed master requests, master i at slice i
//   m_dat_o                     read data, shared by all masters
//   m_ack_o/m_err_o/m_int_o     per-master ack, error and JSP interrupt
//   s_*_o                       request towards the JSP slave
//   s_dat_i/s_ack_i/s_err_i/
//   s_int_i                     slave response and interrupt
// ---------------------------------------------------------------------------
module peripheral_dbg_pu_or1k_jsp_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS*32-1:0] m_adr_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_int_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_int_i
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_MASTER = GW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0]   owner_reg, owner_next;
  logic            owner_valid_reg, owner_valid_next;
  logic [TW-1:0]   timer_reg, timer_next;

  logic [NUM_MASTERS-1:0] req;
  logic [GW-1:0]          pick_idx;
  logic [GW-1:0]          grant_inc;

  // Signals of the currently granted master
  logic [31:0] g_adr, g_dat;
  logic [3:0]  g_sel;
  logic [2:0]  g_cti;
  logic [1:0]  g_bte;
  logic        g_we, g_cyc, g_stb;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign req[gi]     = m_cyc_i[gi] & m_stb_i[gi];
      // Interrupt goes only to the core that last fed the TX FIFO
      assign m_int_o[gi] = s_int_i & owner_valid_reg & (owner_reg == GW'(gi));
    end
  endgenerate

  always_comb begin
    g_adr = m_adr_i[32*int'(grant_reg) +: 32];
    g_dat = m_dat_i[32*int'(grant_reg) +: 32];
    g_sel = m_sel_i[4*int'(grant_reg) +: 4];
    g_cti = m_cti_i[3*int'(grant_reg) +: 3];
    g_bte = m_bte_i[2*int'(grant_reg) +: 2];
    g_we  = m_we_i[grant_reg];
    g_cyc = m_cyc_i[grant_reg];
    g_stb = m_stb_i[grant_reg];
  end

  // First requester at or after rr_ptr. Walking the offsets downwards lets
  // the smallest offset overwrite the others, so it wins.
  always_comb begin
    int pos;
    pick_idx = '0;
    pos      = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      pos = int'(rr_ptr_reg) + k;
      if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
      if (req[pos]) pick_idx = GW'(pos);
    end
  end

  assign grant_inc = (grant_reg == LAST_MASTER) ? '0 : grant_reg + 1'b1;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      rr_ptr_reg      <= '0;
      owner_reg       <= '0;
      owner_valid_reg <= 1'b0;
      timer_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      rr_ptr_reg      <= rr_ptr_next;
      owner_reg       <= owner_next;
      owner_valid_reg <= owner_valid_next;
      timer_reg       <= timer_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    rr_ptr_next      = rr_ptr_reg;
    owner_next       = owner_reg;
    owner_valid_next = owner_valid_reg;
    timer_next       = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;

    unique case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next = pick_idx;
          state_next = BUSY;
        end
      end

      BUSY: begin
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        s_sel_o = g_sel;
        s_we_o  = g_we;
        s_cyc_o = g_cyc;
        s_stb_o = g_stb;
        s_cti_o = g_cti;
        s_bte_o = g_bte;
        m_dat_o = s_dat_i;
        m_ack_o[grant_reg] = s_ack_i;
        m_err_o[grant_reg] = s_err_i;

        if (!g_cyc) begin
          // End of the master's cycle: release and move the pointer past it
          state_next  = IDLE;
          rr_ptr_next = grant_inc;
        end else if (s_ack_i || s_err_i) begin
          // A response restarts the hang timer; ack beats a terminal count
          if (s_ack_i && g_stb && g_we && !g_adr[2] && g_sel[3]) begin
            owner_next       = grant_reg;
            owner_valid_next = 1'b1;
          end
        end else if (g_stb) begin
          if (timer_reg == TIMER_LAST) begin
            m_err_o[grant_reg] = 1'b1;
            state_next         = ABORT;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end else begin
          // Cycle held without strobe: the timer pauses
          timer_next = timer_reg;
        end
      end

      ABORT: begin
        // Slave is disconnected; wait for the master to abandon its cycle
        if (!g_cyc) begin
          state_next  = IDLE;
          rr_ptr_next = grant_inc;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
